// File: rtl/ps2_pkg.sv
// Shared PS/2 key-event layout, modifier scancodes and status word field offsets.
package ps2_pkg;

  localparam int unsigned KEY_EVT_W = 10;
  localparam int unsigned SC_W      = 8;
  localparam int unsigned EVT_EXT   = 9;
  localparam int unsigned EVT_BRK   = 8;

  localparam logic [SC_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [SC_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [SC_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [SC_W-1:0] SC_ALT    = 8'h11;
  localparam logic [SC_W-1:0] SC_CAPS   = 8'h58;

  localparam int unsigned SW_OVF      = 31;
  localparam int unsigned SW_FULL     = 30;
  localparam int unsigned SW_EMPTY    = 29;
  localparam int unsigned SW_CAPS     = 28;
  localparam int unsigned SW_ALT      = 27;
  localparam int unsigned SW_CTRL     = 26;
  localparam int unsigned SW_SHIFT    = 25;
  localparam int unsigned SW_CNT_LSB  = 16;
  localparam int unsigned SW_CNT_W    = 9;
  localparam int unsigned SW_DATA_LSB = 0;

  typedef struct packed {
    logic            ext;
    logic            brk;
    logic [SC_W-1:0] sc;
  } key_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; push/pop are requests, qualified internally against full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_buffer.sv
// Queues decoded PS/2 key events for the CPU, tracks modifier state and packs the MMIO status word.
module ps2_key_buffer
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [KEY_EVT_W-1:0] key_code,
  input  logic                 rd,
  input  logic                 clr_ovf,
  output logic [KEY_EVT_W-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  output logic                 shift,
  output logic                 ctrl,
  output logic                 alt,
  output logic                 caps_lock,
  output logic [31:0]          status_word
);

  key_evt_t evt;
  logic     drop;
  logic     lshift_held;
  logic     rshift_held;
  logic     caps_held;

  assign evt = key_code;

  sync_fifo #(
    .WIDTH  (KEY_EVT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (key_valid),
    .pop     (rd),
    .wr_data (key_code),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // A full FIFO only makes room when the same cycle pops (full implies non-empty).
  assign drop = key_valid && full && !rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Tracker observes every strobed event, dropped or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      ctrl        <= 1'b0;
      alt         <= 1'b0;
      caps_lock   <= 1'b0;
      caps_held   <= 1'b0;
    end else if (key_valid) begin
      if (!evt.ext && evt.sc == SC_LSHIFT) lshift_held <= !evt.brk;
      if (!evt.ext && evt.sc == SC_RSHIFT) rshift_held <= !evt.brk;
      if (evt.sc == SC_CTRL) ctrl <= !evt.brk;
      if (evt.sc == SC_ALT)  alt  <= !evt.brk;
      if (!evt.ext && evt.sc == SC_CAPS) begin
        if (evt.brk) begin
          caps_held <= 1'b0;
        end else if (!caps_held) begin
          caps_lock <= !caps_lock;
          caps_held <= 1'b1;
        end
      end
    end
  end

  assign shift = lshift_held | rshift_held;

  always_comb begin
    status_word                                  = '0;
    status_word[SW_OVF]                          = overflow;
    status_word[SW_FULL]                         = full;
    status_word[SW_EMPTY]                        = empty;
    status_word[SW_CAPS]                         = caps_lock;
    status_word[SW_ALT]                          = alt;
    status_word[SW_CTRL]                         = ctrl;
    status_word[SW_SHIFT]                        = shift;
    status_word[SW_CNT_LSB +: SW_CNT_W]          = SW_CNT_W'(count);
    status_word[SW_DATA_LSB +: KEY_EVT_W]        = rd_data;
  end

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Directed plus randomized checks of ps2_key_buffer against a queue-based behavioural model.
module tb_ps2_key_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [9:0]  key_code;
  logic        rd;
  logic        clr_ovf;
  logic [9:0]  rd_data;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        shift;
  logic        ctrl;
  logic        alt;
  logic        caps_lock;
  logic [31:0] status_word;

  ps2_key_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .rd          (rd),
    .clr_ovf     (clr_ovf),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .shift       (shift),
    .ctrl        (ctrl),
    .alt         (alt),
    .caps_lock   (caps_lock),
    .status_word (status_word)
  );

  always #5 clk = ~clk;

  // Behavioural model: event queue plus modifier flags
  logic [9:0] q[$];
  bit m_ovf, m_lsh, m_rsh, m_ctrl, m_alt, m_caps, m_caps_held;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0; m_caps = 0; m_caps_held = 0;
  endfunction

  function automatic void model_apply(input logic kv, input logic [9:0] kc, input logic r, input logic c);
    bit popping, accept, ext, brk;
    logic [7:0] sc;
    popping = r && (q.size() > 0);
    accept  = kv && ((q.size() < DEPTH) || popping);
    if (popping) void'(q.pop_front());
    if (accept)  q.push_back(kc);
    if (kv && !accept) m_ovf = 1;
    else if (c)        m_ovf = 0;
    if (kv) begin
      ext = kc[9]; brk = kc[8]; sc = kc[7:0];
      if (!ext && sc == 8'h12) m_lsh = !brk;
      if (!ext && sc == 8'h59) m_rsh = !brk;
      if (sc == 8'h14) m_ctrl = !brk;
      if (sc == 8'h11) m_alt  = !brk;
      if (!ext && sc == 8'h58) begin
        if (brk) m_caps_held = 0;
        else if (!m_caps_held) begin
          m_caps = !m_caps;
          m_caps_held = 1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_status();
    logic [9:0] head;
    int cnt;
    cnt  = q.size();
    head = (cnt > 0) ? q[0] : 10'h000;
    return {m_ovf, 1'(cnt == DEPTH), 1'(cnt == 0), m_caps, m_alt, m_ctrl, m_lsh | m_rsh,
            9'(cnt), 6'b0, head};
  endfunction

  function automatic logic [31:0] exp_ports();
    logic [9:0] head;
    int cnt;
    cnt  = q.size();
    head = (cnt > 0) ? q[0] : 10'h000;
    return 32'({m_ovf, 1'(cnt == DEPTH), 1'(cnt == 0), m_caps, m_alt, m_ctrl, m_lsh | m_rsh,
                5'(cnt), head});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".status"}, status_word, exp_status());
    chk({tag, ".ports"},
        32'({overflow, full, empty, caps_lock, alt, ctrl, shift, count, rd_data}),
        exp_ports());
  endtask

  // One clock of stimulus; inputs last exactly one cycle, outputs sampled 1ns after the edge
  task automatic step(input string tag, input logic kv, input logic [9:0] kc,
                      input logic r, input logic c);
    @(negedge clk);
    key_valid = kv; key_code = kc; rd = r; clr_ovf = c;
    @(posedge clk);
    #1;
    key_valid = 0; key_code = '0; rd = 0; clr_ovf = 0;
    model_apply(kv, kc, r, c);
    check_all(tag);
  endtask

  function automatic logic [9:0] rand_code();
    logic [7:0] mods [5];
    mods = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
    if ($urandom_range(0, 7) < 3) return {2'($urandom_range(0, 3)), mods[$urandom_range(0, 4)]};
    return 10'($urandom);
  endfunction

  task automatic rand_step(input string tag);
    logic kv, r, c;
    kv = ($urandom_range(0, 3) != 0);
    r  = ($urandom_range(0, 2) == 0);
    c  = ($urandom_range(0, 9) == 0);
    step(tag, kv, rand_code(), r, c);
  endtask

  initial begin
    rst = 0; key_valid = 0; key_code = '0; rd = 0; clr_ovf = 0;
    model_reset();
    #1;
    chk("reset.status_const", status_word, 32'h2000_0000);
    check_all("reset");
    @(negedge clk);
    rst = 1;

    // Basic push/pop and FWFT head
    step("t1.push0", 1, 10'h01C, 0, 0);
    step("t1.push1", 1, 10'h11C, 0, 0);
    chk("t1.count2", 32'(count), 32'd2);
    chk("t1.head", 32'(rd_data), 32'h01C);
    step("t1.pop0", 0, '0, 1, 0);
    chk("t1.head2", 32'(rd_data), 32'h11C);
    step("t1.pop1", 0, '0, 1, 0);
    chk("t1.empty_data", 32'({empty, rd_data}), 32'h400);

    // Fill past capacity, overflow priority, then clear
    for (int i = 0; i < 17; i++) step("t2.fill", 1, 10'(10'h020 + i), 0, 0);
    chk("t2.full", 32'({full, overflow, count}), 32'({1'b1, 1'b1, 5'd16}));
    step("t2.clr_vs_set", 1, 10'h0AA, 0, 1);
    chk("t2.ovf_sticky", 32'(overflow), 32'd1);
    step("t2.clr", 0, '0, 0, 1);
    chk("t2.ovf_clr", 32'(overflow), 32'd0);

    // Simultaneous push+pop at full and empty; pop while empty
    step("t3.full_pushpop", 1, 10'h0BB, 1, 0);
    chk("t3.full_head", 32'({count, rd_data}), 32'({5'd16, 10'h021}));
    for (int i = 0; i < 16; i++) step("t3.drain", 0, '0, 1, 0);
    step("t3.empty_pushpop", 1, 10'h0CC, 1, 0);
    chk("t3.empty_kept", 32'({count, rd_data}), 32'({5'd1, 10'h0CC}));
    step("t3.pop", 0, '0, 1, 0);
    step("t3.underflow", 0, '0, 1, 0);
    chk("t3.underflow_state", status_word, 32'h2000_0000);

    // Shift/ctrl tracking
    step("t4.lsh", 1, 10'h012, 0, 0);
    step("t4.rsh", 1, 10'h059, 0, 0);
    step("t4.lsh_brk", 1, 10'h112, 0, 0);
    chk("t4.shift_held", 32'(shift), 32'd1);
    step("t4.rsh_brk", 1, 10'h159, 0, 0);
    chk("t4.shift_rel", 32'(shift), 32'd0);
    step("t4.ctrl_e0", 1, 10'h214, 0, 0);
    chk("t4.ctrl_set", 32'(ctrl), 32'd1);
    step("t4.ctrl_e0_brk", 1, 10'h314, 0, 0);
    chk("t4.ctrl_rel", 32'(ctrl), 32'd0);

    // Caps lock with typematic repeats
    step("t5.caps0", 1, 10'h058, 0, 0);
    step("t5.caps_rep", 1, 10'h058, 0, 0);
    step("t5.caps_rep", 1, 10'h058, 0, 0);
    step("t5.caps_brk", 1, 10'h158, 0, 0);
    chk("t5.caps_on", 32'(caps_lock), 32'd1);
    step("t5.caps1", 1, 10'h058, 0, 0);
    step("t5.caps1_brk", 1, 10'h158, 0, 0);
    chk("t5.caps_off", 32'(caps_lock), 32'd0);
    while (q.size() > 0) step("t5.drain", 0, '0, 1, 0);

    // Pointer wrap with steady push+pop traffic
    for (int i = 0; i < 3; i++) step("t6.prefill", 1, 10'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step("t6.wrap", 1, 10'($urandom), 1, 0);

    // Random traffic, async reset mid-burst, then more traffic
    for (int i = 0; i < 300; i++) rand_step("rand_a");
    @(posedge clk);
    #3;
    rst = 0;
    key_valid = 1; key_code = 10'h058; rd = 0;
    #1;
    model_reset();
    chk("t6.async_rst", status_word, 32'h2000_0000);
    check_all("t6.async_rst");
    @(posedge clk);
    #1;
    key_valid = 0; key_code = '0;
    chk("t6.rst_held", status_word, 32'h2000_0000);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 300; i++) rand_step("rand_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
